// File: rtl/hazard_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : hazard_ctrl                                                  |
// | Description : Pipeline hazard controller for the 5-stage RV32I core.       |
// |               Tracks the EX/MEM destination registers, produces the        |
// |               registered EX-stage operand bypass selects, the load-use     |
// |               stall and the EX redirect flush.                             |
// | Option      : HAZARD_PERF_CNT_EN adds stall_cnt / flush_cnt (32-bit)       |
// |               cycle counters.                                              |
// | Ports       : clk, reset (async, active-high)                              |
// |               id_*        decode-slot instruction description              |
// |               ex_pc_src   redirect resolved in EX                          |
// |               alu_src_a/b registered bypass selects for the EX instruction |
// |               stall       hold PC and IF/ID, bubble into ID/EX             |
// |               flush       squash IF/ID and ID/EX                           |
// |               stall_cnt / flush_cnt (optional) performance counters       |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+

package alu_src;
  typedef enum logic [1:0] {
    IMM = 2'b00,
    MEM = 2'b01,
    EX  = 2'b10,
    REG = 2'b11
  } AluSrc;
endpackage

package instr_decode;
  typedef enum logic [1:0] {
    ALU = 2'b00,
    MEM = 2'b01,
    PC4 = 2'b10,
    IMM = 2'b11
  } RegSrc;
endpackage

package pc_src;
  // 2'b11 is left undefined and behaves like PC4.
  typedef enum logic [1:0] {
    PC4    = 2'b00,
    BRANCH = 2'b01,
    JUMP   = 2'b10
  } PCSrc;
endpackage

module hazard_ctrl #(
  parameter int XREG_BITS = 5
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 id_valid,
  input  logic [XREG_BITS-1:0] id_rs1,
  input  logic [XREG_BITS-1:0] id_rs2,
  input  logic                 id_use_rs1,
  input  logic                 id_use_rs2,
  input  logic                 id_b_imm,
  input  logic [XREG_BITS-1:0] id_rd,
  input  logic                 id_reg_write,
  input  instr_decode::RegSrc  id_reg_src,
  input  pc_src::PCSrc         ex_pc_src,
  output alu_src::AluSrc       alu_src_a,
  output alu_src::AluSrc       alu_src_b,
  output logic                 stall,
  output logic                 flush
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [31:0]          stall_cnt,
  output logic [31:0]          flush_cnt
`endif
);

  // EX slot mirrors ID/EX, MEM slot mirrors EX/MEM.
  logic                 r_ex_valid;
  logic [XREG_BITS-1:0] r_ex_rd;
  logic                 r_ex_we;
  logic                 r_ex_load;
  logic                 r_mem_valid;
  logic [XREG_BITS-1:0] r_mem_rd;
  logic                 r_mem_we;
  alu_src::AluSrc       r_src_a;
  alu_src::AluSrc       r_src_b;

  logic                 w_ex_hit_rs1;
  logic                 w_ex_hit_rs2;
  logic                 w_mem_hit_rs1;
  logic                 w_mem_hit_rs2;
  logic                 w_flush;
  logic                 w_stall;
  logic                 w_bubble;
  alu_src::AluSrc       w_sel_a;
  alu_src::AluSrc       w_sel_b;

  // x0 is hard-wired zero, so it never has a producer.
  function automatic logic f_match(
    input logic                 valid,
    input logic                 we,
    input logic [XREG_BITS-1:0] rd,
    input logic [XREG_BITS-1:0] rs
  );
    return valid && we && (rd == rs) && (rs != '0);
  endfunction

  // Youngest producer (EX) takes precedence over the older one (MEM).
  function automatic alu_src::AluSrc f_sel(
    input logic use_rs,
    input logic hit_ex,
    input logic hit_mem
  );
    if (!use_rs)      return alu_src::REG;
    else if (hit_ex)  return alu_src::EX;
    else if (hit_mem) return alu_src::MEM;
    else              return alu_src::REG;
  endfunction

  always_comb begin
    w_ex_hit_rs1  = f_match(r_ex_valid,  r_ex_we,  r_ex_rd,  id_rs1);
    w_ex_hit_rs2  = f_match(r_ex_valid,  r_ex_we,  r_ex_rd,  id_rs2);
    w_mem_hit_rs1 = f_match(r_mem_valid, r_mem_we, r_mem_rd, id_rs1);
    w_mem_hit_rs2 = f_match(r_mem_valid, r_mem_we, r_mem_rd, id_rs2);

    // Reset gating keeps both outputs at 0 while reset is held, even if
    // the EX stage is presenting a redirect.
    w_flush = !reset &&
              ((ex_pc_src == pc_src::JUMP) || (ex_pc_src == pc_src::BRANCH));

    // A redirect squashes the consumer anyway, so it overrides the stall.
    w_stall = !reset && !w_flush && id_valid && r_ex_load &&
              ((id_use_rs1 && w_ex_hit_rs1) || (id_use_rs2 && w_ex_hit_rs2));

    w_bubble = w_stall || w_flush || !id_valid;

    w_sel_a = f_sel(id_use_rs1, w_ex_hit_rs1, w_mem_hit_rs1);
    w_sel_b = id_b_imm ? alu_src::IMM
                       : f_sel(id_use_rs2, w_ex_hit_rs2, w_mem_hit_rs2);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ex_valid  <= 1'b0;
      r_ex_rd     <= '0;
      r_ex_we     <= 1'b0;
      r_ex_load   <= 1'b0;
      r_mem_valid <= 1'b0;
      r_mem_rd    <= '0;
      r_mem_we    <= 1'b0;
      r_src_a     <= alu_src::REG;
      r_src_b     <= alu_src::REG;
    end else begin
      r_mem_valid <= r_ex_valid;
      r_mem_rd    <= r_ex_rd;
      r_mem_we    <= r_ex_we;

      r_ex_valid  <= !w_bubble;
      r_ex_rd     <= id_rd;
      r_ex_we     <= id_reg_write && !w_bubble;
      r_ex_load   <= (id_reg_src == instr_decode::MEM) && !w_bubble;

      r_src_a     <= w_bubble ? alu_src::REG : w_sel_a;
      r_src_b     <= w_bubble ? alu_src::REG : w_sel_b;
    end
  end

  assign alu_src_a = r_src_a;
  assign alu_src_b = r_src_b;
  assign stall     = w_stall;
  assign flush     = w_flush;

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] r_stall_cnt;
  logic [31:0] r_flush_cnt;

  // Free-running; wraps naturally from 0xFFFFFFFF to 0.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (w_stall) r_stall_cnt <= r_stall_cnt + 32'd1;
      if (w_flush) r_flush_cnt <= r_flush_cnt + 32'd1;
    end
  end

  assign stall_cnt = r_stall_cnt;
  assign flush_cnt = r_flush_cnt;
`endif

endmodule

`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_hazard_ctrl                                               |
// | Description : Self-checking bench for hazard_ctrl: directed scenarios plus |
// |               randomized traffic compared against a pipeline-level model. |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_hazard_ctrl;

  logic                clk;
  logic                reset;
  logic                id_valid;
  logic [4:0]          id_rs1;
  logic [4:0]          id_rs2;
  logic                id_use_rs1;
  logic                id_use_rs2;
  logic                id_b_imm;
  logic [4:0]          id_rd;
  logic                id_reg_write;
  instr_decode::RegSrc id_reg_src;
  pc_src::PCSrc        ex_pc_src;
  alu_src::AluSrc      alu_src_a;
  alu_src::AluSrc      alu_src_b;
  logic                stall;
  logic                flush;
`ifdef HAZARD_PERF_CNT_EN
  logic [31:0]         stall_cnt;
  logic [31:0]         flush_cnt;
`endif

  hazard_ctrl #(.XREG_BITS(5)) dut (
    .clk          (clk),
    .reset        (reset),
    .id_valid     (id_valid),
    .id_rs1       (id_rs1),
    .id_rs2       (id_rs2),
    .id_use_rs1   (id_use_rs1),
    .id_use_rs2   (id_use_rs2),
    .id_b_imm     (id_b_imm),
    .id_rd        (id_rd),
    .id_reg_write (id_reg_write),
    .id_reg_src   (id_reg_src),
    .ex_pc_src    (ex_pc_src),
    .alu_src_a    (alu_src_a),
    .alu_src_b    (alu_src_b),
    .stall        (stall),
    .flush        (flush)
`ifdef HAZARD_PERF_CNT_EN
    ,
    .stall_cnt    (stall_cnt),
    .flush_cnt    (flush_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // pipe[0] = instruction in EX, pipe[1] = instruction in MEM.
  typedef struct {
    bit v;
    int rd;
    bit we;
    bit ld;
  } slot_t;

  slot_t pipe[$];
  int    exp_a, exp_b;         // selects for the instruction now in EX (3=REG 2=EX 1=MEM 0=IMM)
  longint exp_scnt, exp_fcnt;
  bit    last_stall, last_flush;

  function automatic void model_reset();
    slot_t e;
    e.v = 0; e.rd = 0; e.we = 0; e.ld = 0;
    pipe.delete();
    pipe.push_back(e);
    pipe.push_back(e);
    exp_a = 3; exp_b = 3;
    exp_scnt = 0; exp_fcnt = 0;
  endfunction

  // Nearest older writer of rs: 2 if in EX, 1 if in MEM, 3 if none.
  function automatic int producer(input int rs);
    int r;
    r = 3;
    if (rs != 0)
      for (int i = 1; i >= 0; i--)
        if (pipe[i].v && pipe[i].we && pipe[i].rd == rs) r = (i == 0) ? 2 : 1;
    return r;
  endfunction

  // One decode cycle: drive, check the current cycle, then advance the model.
  task automatic step(input bit v, input int rs1, input int rs2, input bit u1, input bit u2,
                      input bit bimm, input int rd, input bit we, input int rsrc, input int pcs);
    bit    e_flush, e_stall, acc;
    int    na, nb;
    slot_t e;
    @(negedge clk);
    id_valid     = v;
    id_rs1       = 5'(rs1);
    id_rs2       = 5'(rs2);
    id_use_rs1   = u1;
    id_use_rs2   = u2;
    id_b_imm     = bimm;
    id_rd        = 5'(rd);
    id_reg_write = we;
    id_reg_src   = instr_decode::RegSrc'(2'(rsrc));
    ex_pc_src    = pc_src::PCSrc'(2'(pcs));
    #1;
    e_flush = (pcs == 1) || (pcs == 2);
    e_stall = !e_flush && v && pipe[0].ld &&
              ((u1 && producer(rs1) == 2) || (u2 && producer(rs2) == 2));
    last_stall = stall;
    last_flush = flush;
    chk("stall", stall, e_stall);
    chk("flush", flush, e_flush);
    chk("sel_a", alu_src_a, exp_a);
    chk("sel_b", alu_src_b, exp_b);
    acc = v && !e_stall && !e_flush;
    na  = !acc ? 3 : (u1 ? producer(rs1) : 3);
    nb  = !acc ? 3 : (bimm ? 0 : (u2 ? producer(rs2) : 3));
    e.v = acc; e.rd = rd; e.we = we; e.ld = (rsrc == 1);
    @(posedge clk);
    pipe.push_front(e);
    void'(pipe.pop_back());
    exp_a = na;
    exp_b = nb;
    exp_scnt += e_stall;
    exp_fcnt += e_flush;
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    reset = 1'b1;
    id_valid = 0; id_rs1 = 0; id_rs2 = 0; id_use_rs1 = 0; id_use_rs2 = 0;
    id_b_imm = 0; id_rd = 0; id_reg_write = 0;
    id_reg_src = instr_decode::ALU;
    ex_pc_src  = pc_src::PC4;
    model_reset();
    #2;
    chk("rst_sel_a", alu_src_a, 3);
    chk("rst_sel_b", alu_src_b, 3);
    chk("rst_stall", stall, 0);
    chk("rst_flush", flush, 0);
`ifdef HAZARD_PERF_CNT_EN
    chk("rst_scnt", stall_cnt, 0);
    chk("rst_fcnt", flush_cnt, 0);
`endif
    @(negedge clk);
    reset = 1'b0;
    idle();

    // addi x5 ; add x6,x5,x5 -> EX/EX
    step(1, 0, 0, 1, 0, 1, 5, 1, 0, 0);
    step(1, 5, 5, 1, 1, 0, 6, 1, 0, 0);
    #1;
    chk("fwd_ex_a", alu_src_a, 2);
    chk("fwd_ex_b", alu_src_b, 2);
    chk("fwd_ex_stall", last_stall, 0);
    idle(); idle();

    // addi x5 ; nop ; add x6,x5,x1 -> MEM/REG
    step(1, 0, 0, 1, 0, 1, 5, 1, 0, 0);
    step(1, 0, 0, 1, 0, 1, 0, 1, 0, 0);
    step(1, 5, 1, 1, 1, 0, 6, 1, 0, 0);
    #1;
    chk("fwd_mem_a", alu_src_a, 1);
    chk("fwd_mem_b", alu_src_b, 3);
    idle(); idle();

    // lw x7 ; add x8,x7,x0 -> one stall, one bubble, then MEM
    step(1, 1, 0, 1, 0, 1, 7, 1, 1, 0);
    step(1, 7, 0, 1, 1, 0, 8, 1, 0, 0);
    chk("lu_stall", last_stall, 1);
    #1;
    chk("lu_bubble_a", alu_src_a, 3);
    step(1, 7, 0, 1, 1, 0, 8, 1, 0, 0);
    chk("lu_restall", last_stall, 0);
    #1;
    chk("lu_mem_a", alu_src_a, 1);
    chk("lu_x0_b", alu_src_b, 3);
    idle(); idle();

    // writer/load to x0 followed by reader of x0
    step(1, 0, 0, 1, 0, 1, 0, 1, 0, 0);
    step(1, 0, 0, 1, 1, 0, 9, 1, 0, 0);
    #1;
    chk("x0_sel_a", alu_src_a, 3);
    step(1, 1, 0, 1, 0, 1, 0, 1, 1, 0);
    step(1, 0, 0, 1, 1, 0, 9, 1, 0, 0);
    chk("x0_no_stall", last_stall, 0);
    idle(); idle();

    // branch in the same cycle as a load-use
    step(1, 1, 0, 1, 0, 1, 7, 1, 1, 0);
    step(1, 7, 7, 1, 1, 0, 8, 1, 0, 1);
    chk("br_flush", last_flush, 1);
    chk("br_stall", last_stall, 0);
    #1;
    chk("br_bubble_a", alu_src_a, 3);
    chk("br_bubble_b", alu_src_b, 3);
    // back-to-back redirects, including the undefined encoding
    step(1, 1, 1, 1, 1, 0, 3, 1, 0, 2);
    step(1, 1, 1, 1, 1, 0, 3, 1, 0, 2);
    step(1, 1, 1, 1, 1, 0, 3, 1, 0, 3);
    chk("pc11_flush", last_flush, 0);
    idle(); idle();

    // random traffic on a small register set to provoke hazards
    for (int i = 0; i < 400; i++) begin
      int r, p;
      r = $urandom_range(0, 9);
      p = (r < 2) ? 1 + int'($urandom_range(0, 1)) : ((r == 2) ? 3 : 0);
      step(($urandom_range(0, 7) != 0), $urandom_range(0, 3), $urandom_range(0, 3),
           $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1),
           $urandom_range(0, 3), $urandom_range(0, 1), $urandom_range(0, 3), p);
    end

`ifdef HAZARD_PERF_CNT_EN
    #1;
    chk("scnt", stall_cnt, 32'(exp_scnt));
    chk("fcnt", flush_cnt, 32'(exp_fcnt));
`endif

    // asynchronous reset in the middle of a load-use stall
    idle(); idle();
    step(1, 0, 0, 1, 0, 1, 5, 1, 0, 0);
    step(1, 5, 0, 1, 0, 1, 9, 1, 1, 0);
    @(negedge clk);
    id_valid = 1; id_rs1 = 5'd9; id_use_rs1 = 1; id_use_rs2 = 0; id_b_imm = 1;
    id_rd = 5'd10; id_reg_write = 1; id_reg_src = instr_decode::ALU;
    ex_pc_src = pc_src::PC4;
    #1;
    chk("pre_rst_stall", stall, 1);
    chk("pre_rst_sel_a", alu_src_a, 2);
    reset = 1'b1;
    #1;
    chk("arst_stall", stall, 0);
    chk("arst_sel_a", alu_src_a, 3);
    chk("arst_sel_b", alu_src_b, 3);
`ifdef HAZARD_PERF_CNT_EN
    chk("arst_scnt", stall_cnt, 0);
    chk("arst_fcnt", flush_cnt, 0);
`endif
    id_valid = 0;
    #1;
    reset = 1'b0;
    model_reset();
    @(posedge clk);
    idle();
    step(1, 9, 0, 1, 0, 1, 10, 1, 0, 0);
    idle();

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard controller for the 5-stage RV32I core. It tracks the destination registers of the instructions in EX and MEM and produces the registered `AluSrc` bypass selects consumed by the EX-stage operand muxes. It also produces the load-use stall and the redirect flush driven by the EX-stage `PCSrc`. It sits beside the ID/EX pipeline register and produces the encodings that the datapath muxes consume.

## Interface
Parameters:
- `XREG_BITS`, 5, register index width.

Ports:
- `clk` in 1: core clock; all state updates on the rising edge.
- `reset` in 1: asynchronous, active-high.
- `id_valid` in 1: the decode slot holds a real instruction.
- `id_rs1`, `id_rs2` in `XREG_BITS`: decode source registers.
- `id_use_rs1`, `id_use_rs2` in 1: the instruction reads the operand.
- `id_b_imm` in 1: operand B is the immediate.
- `id_rd` in `XREG_BITS`: decode destination register.
- `id_reg_write` in 1: decode instruction writes `rd`.
- `id_reg_src` in `instr_decode::RegSrc`: `MEM` marks a load.
- `ex_pc_src` in `pc_src::PCSrc`: redirect resolved in EX.
- `alu_src_a`, `alu_src_b` out `alu_src::AluSrc`: registered selects for the instruction now in EX.
- `stall` out 1: hold PC and IF/ID, and insert a bubble into ID/EX.
- `flush` out 1: squash IF/ID and ID/EX.

## Operation
- Internal slots: EX slot {valid, rd, we, load} and MEM slot {valid, rd, we}. Each slot mirrors the corresponding pipeline register.
- Every edge:
  - The MEM slot takes the EX slot.
  - The EX slot takes the decode instruction, or a bubble (valid=0) when `stall`, `flush` or `!id_valid` is set.
- Producer match for a source register `rs`: the slot is valid, `we`=1, `rd`==`rs`, and `rs`≠0.
- Select computed in ID for operand A (and for operand B when `!id_b_imm`), with first match winning:
  1. Match in the EX slot gives `EX` (2'b10). The youngest producer wins.
  2. Match in the MEM slot gives `MEM` (2'b01).
  3. Otherwise the select is `REG` (2'b11).
- When `id_b_imm`=1, operand B select is `IMM` (2'b00).
- Computed selects are registered into `alu_src_a/b`. When the EX slot loads a bubble, `alu_src_a/b` load `REG`.
- An operand with `id_use_*`=0 gets `REG` (or `IMM` for B), never a bypass.
- Load-use: `stall` = `id_valid` & EX slot valid & load & a match on a used rs1/rs2. x0 is never a match.
- Redirect: `flush` = (`ex_pc_src`==`JUMP` | `ex_pc_src`==`BRANCH`). The undefined encoding 2'b11 is treated as `PC4`.
- Flush has priority over stall. When `flush`=1, `stall` is forced to 0.
- A WB-stage producer needs no bypass, because the register file writes before it reads.

## Timing
- Reset values:
  - `alu_src_a` = `alu_src_b` = `REG`.
  - `stall` = 0 and `flush` = 0.
  - Both slots invalid.
- `stall` and `flush` are combinational from the current inputs and slot state, and apply in the same cycle.
- Select latency: 1 cycle. Selects are valid for the whole cycle the instruction occupies EX.
- A stalled load-use consumer re-evaluates the next cycle. The load is then in the MEM slot, so the consumer gets `MEM`, with exactly one bubble.
- Back-to-back redirects: each cycle with `flush` inserts a bubble, and no count accumulates.
- `reset` asserted mid-operation clears the slots and outputs immediately, without waiting for a clock edge.

## Configuration
- `HAZARD_PERF_CNT_EN`: when defined, adds two outputs, `stall_cnt` and `flush_cnt`.
  - Both are 32 bits and count cycles with `stall` and with `flush` respectively.
  - Both reset to 0 and wrap from 0xFFFFFFFF to 0.
- When the macro is undefined, the ports and logic are absent and behaviour is otherwise identical.

## Test plan
- `addi x5`, then next cycle `add x6,x5,x5` → `alu_src_a`=`alu_src_b`=`EX` in the consumer's EX cycle, and `stall`=0.
- `addi x5`, then `nop`, then `add x6,x5,x1` → `alu_src_a`=`MEM` and `alu_src_b`=`REG`.
- `lw x7`, then `add x8,x7,x0` → `stall`=1 for one cycle and one bubble (selects `REG`), then `alu_src_a`=`MEM`.
- Writer to x0, then a reader of x0 → `alu_src_a`=`REG` and `stall`=0. A load to x0 followed by a read of x0 causes no stall.
- `ex_pc_src`=`BRANCH` in the same cycle as a load-use condition → `flush`=1 and `stall`=0, and the EX slot becomes a bubble.
- `reset` pulsed between clock edges during a stall → `stall`=0 and selects=`REG` immediately. With `HAZARD_PERF_CNT_EN`, the counters also read 0.
